// File: rtl/mioc_dram_arbiter_pkg.sv
// Shared state encodings and parameter defaults for the MIOC DRAM sequencer and bus arbiter.
// The optional DMA request timeout is enabled with MIOC_DMA_TIMEOUT_EN.
package mioc_dram_arbiter_pkg;

    localparam logic [2:0] DRAM_IDLE = 3'd0;
    localparam logic [2:0] DRAM_ROW  = 3'd1;
    localparam logic [2:0] DRAM_COL  = 3'd2;
    localparam logic [2:0] DRAM_CAS  = 3'd3;
    localparam logic [2:0] DRAM_RFSH = 3'd4;
    localparam logic [2:0] DRAM_PRE  = 3'd5;

    localparam logic [1:0] BUS_CPU = 2'd0;
    localparam logic [1:0] BUS_REQ = 2'd1;
    localparam logic [1:0] BUS_DMA = 2'd2;
    localparam logic [1:0] BUS_REL = 2'd3;

    localparam int unsigned PRECHARGE_CYC_DEF = 1;
    localparam int unsigned DMA_TIMEOUT_DEF   = 255;

endpackage

// File: rtl/mioc_dram_arbiter_bus_arb.sv
// Bus-ownership FSM (CPU/REQ/DMA/REL) between the Z80 and the 6801 DMA master.
// MIOC_DMA_TIMEOUT_EN adds a BUSAK_N timeout with a sticky DMA_ERR flag.
module mioc_bus_arb
  import mioc_dram_arbiter_pkg::*;
#(
  parameter int unsigned DMA_TIMEOUT = DMA_TIMEOUT_DEF
) (
  input  logic B_PHI,
  input  logic RST,
  input  logic DMA_N,
  input  logic BUSAK_N,
  input  logic dram_idle,
  output logic BUSRQ_N,
  output logic ADDRBUFEN_N,
  output logic DMA_ERR
);

  logic [1:0] state;
  logic [1:0] state_nxt;

`ifdef MIOC_DMA_TIMEOUT_EN
  localparam int unsigned TMO_W = (DMA_TIMEOUT > 1) ? $clog2(DMA_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DMA_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             blocked;

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      BUS_CPU: begin
`ifdef MIOC_DMA_TIMEOUT_EN
        if (!DMA_N && !blocked) state_nxt = BUS_REQ;
`else
        if (!DMA_N) state_nxt = BUS_REQ;
`endif
      end
      BUS_REQ: begin
        if (DMA_N)         state_nxt = BUS_CPU;
        else if (!BUSAK_N) state_nxt = BUS_DMA;
`ifdef MIOC_DMA_TIMEOUT_EN
        else if (tmo_hit)  state_nxt = BUS_CPU;
`endif
      end
      // Ownership is only handed back once any in-flight DRAM cycle has drained.
      BUS_DMA: if (DMA_N && dram_idle) state_nxt = BUS_REL;
      BUS_REL: if (BUSAK_N) state_nxt = BUS_CPU;
      default: state_nxt = BUS_CPU;
    endcase
  end

  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      state       <= BUS_CPU;
      BUSRQ_N     <= 1'b1;
      ADDRBUFEN_N <= 1'b0;
    end else begin
      state       <= state_nxt;
      BUSRQ_N     <= !((state_nxt == BUS_REQ) || (state_nxt == BUS_DMA));
      ADDRBUFEN_N <= (state_nxt == BUS_DMA);
    end
  end

`ifdef MIOC_DMA_TIMEOUT_EN
  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      tmo_cnt <= '0;
      blocked <= 1'b0;
      DMA_ERR <= 1'b0;
    end else begin
      if (state == BUS_REQ && state_nxt == BUS_REQ) tmo_cnt <= tmo_cnt + 1'b1;
      else                                          tmo_cnt <= '0;
      // A timed-out requester must drop DMA_N before it may ask again.
      if (state == BUS_REQ && !DMA_N && BUSAK_N && tmo_hit) begin
        blocked <= 1'b1;
        DMA_ERR <= 1'b1;
      end else if (DMA_N) begin
        blocked <= 1'b0;
      end
    end
  end
`else
  assign DMA_ERR = 1'b0;
`endif

endmodule

// File: rtl/mioc_dram_arbiter.sv
// DRAM cycle sequencer (RAS/MUX/CAS) for the MIOC, with the bus-ownership arbiter as a sub-block.
// Define MIOC_DMA_TIMEOUT_EN to enable the DMA request timeout and DMA_ERR flag.
module mioc_dram_arbiter
  import mioc_dram_arbiter_pkg::*;
#(
  parameter int unsigned DMA_TIMEOUT   = DMA_TIMEOUT_DEF,
  parameter int unsigned PRECHARGE_CYC = PRECHARGE_CYC_DEF
) (
  input  logic B_PHI,
  input  logic RST,
  input  logic BMREQ_N,
  input  logic BRD_N,
  input  logic N_BWR,
  input  logic BRFSH_N,
  input  logic BA15,
  input  logic RAM_SEL,
  input  logic DMA_N,
  input  logic BUSAK_N,
  output logic RAS_N,
  output logic MUX,
  output logic CAS1_N,
  output logic CAS2_N,
  output logic BUSRQ_N,
  output logic ADDRBUFEN_N,
  output logic BUSY,
  output logic DMA_ERR
);

  localparam int unsigned PRE_W = (PRECHARGE_CYC > 1) ? $clog2(PRECHARGE_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRECHARGE_CYC - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             bank;
  logic [PRE_W-1:0] pre_cnt;
  logic             dram_idle;

  assign dram_idle = (state == DRAM_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      DRAM_IDLE: begin
        if (!BMREQ_N && !BRFSH_N)
          state_nxt = DRAM_RFSH;
        else if (!BMREQ_N && RAM_SEL && (!BRD_N || !N_BWR))
          state_nxt = DRAM_ROW;
      end
      DRAM_ROW:  state_nxt = BMREQ_N ? DRAM_PRE : DRAM_COL;
      DRAM_COL:  state_nxt = BMREQ_N ? DRAM_PRE : DRAM_CAS;
      DRAM_CAS:  if (BMREQ_N) state_nxt = DRAM_PRE;
      DRAM_RFSH: if (BMREQ_N) state_nxt = DRAM_PRE;
      DRAM_PRE:  if (pre_cnt == PRE_LAST) state_nxt = DRAM_IDLE;
      default:   state_nxt = DRAM_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      state   <= DRAM_IDLE;
      bank    <= 1'b0;
      pre_cnt <= '0;
      RAS_N   <= 1'b1;
      MUX     <= 1'b0;
      CAS1_N  <= 1'b1;
      CAS2_N  <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DRAM_IDLE && state_nxt == DRAM_ROW) bank <= BA15;
      if (state == DRAM_PRE && state_nxt == DRAM_PRE) pre_cnt <= pre_cnt + 1'b1;
      else                                            pre_cnt <= '0;
      RAS_N  <= !(state_nxt inside {DRAM_ROW, DRAM_COL, DRAM_CAS, DRAM_RFSH});
      MUX    <= (state_nxt inside {DRAM_COL, DRAM_CAS});
      CAS1_N <= !((state_nxt == DRAM_CAS) && !bank);
      CAS2_N <= !((state_nxt == DRAM_CAS) && bank);
      BUSY   <= (state_nxt != DRAM_IDLE);
    end
  end

  mioc_bus_arb #(
    .DMA_TIMEOUT(DMA_TIMEOUT)
  ) u_bus_arb (
    .B_PHI      (B_PHI),
    .RST        (RST),
    .DMA_N      (DMA_N),
    .BUSAK_N    (BUSAK_N),
    .dram_idle  (dram_idle),
    .BUSRQ_N    (BUSRQ_N),
    .ADDRBUFEN_N(ADDRBUFEN_N),
    .DMA_ERR    (DMA_ERR)
  );

endmodule
